pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all address ports.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-low.
REQ-005 Port stall  input  1  hold the PC (hazard stall from the pipeline).
REQ-006 Port branch_taken  input  1  redirect the PC to branch_target.
REQ-007 Port branch_target  input  XLEN  branch destination address.
REQ-008 Port jump  input  1  redirect the PC to jump_target (JAL/JALR).
REQ-009 Port jump_target  input  XLEN  jump destination address.
REQ-010 Port halt_req  input  1  ECALL/EBREAK/FENCE seen; stop fetching.
REQ-011 Port resume  input  1  leave HALT; ignored in other states.
REQ-012 Port pc  output  XLEN  current fetch address (registered).
REQ-013 Port pc_plus4  output  XLEN  pc + 4, combinational, modulo 2^XLEN.
REQ-014 Port fetch_valid  output  1  pc is a valid fetch address this cycle.
REQ-015 Port halted  output  1  state is HALT.
REQ-016 Port misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-017 Port redirect_count  output  32  number of taken redirects since reset, wraps at 2^32.

Function
REQ-018 The FSM SHALL have exactly three states: BOOT, RUN and HALT, encoded in a registered state variable.
REQ-019 BOOT SHALL last exactly one cycle after rst deasserts, with pc = RESET_PC and fetch_valid = 0, then go to RUN unconditionally.
REQ-020 In RUN, next-PC priority SHALL be, highest first: halt_req, jump, branch_taken, stall, increment.
REQ-021 halt_req in RUN SHALL hold pc, enter HALT next cycle, and override any simultaneous redirect; that redirect is not counted.
REQ-022 jump with jump_target[1:0] == 0 SHALL load pc <= jump_target next cycle, even when stall = 1.
REQ-023 branch_taken with branch_target[1:0] == 0 and jump = 0 SHALL load pc <= branch_target next cycle, even when stall = 1.
REQ-024 A selected redirect whose target has bits [1:0] != 0 SHALL leave pc unchanged, set misaligned, and enter HALT next cycle; it is not counted.
REQ-025 With no redirect and stall = 1, pc SHALL hold; otherwise pc SHALL advance to pc_plus4.
REQ-026 Increment SHALL wrap modulo 2^XLEN (pc = 32'hFFFF_FFFC advances to 0) with no flag raised.
REQ-027 redirect_count SHALL increment by 1 on each cycle where a correctly aligned jump or branch is taken in RUN.
REQ-028 fetch_valid SHALL be 1 in RUN when stall = 0 or a redirect is taken, and 0 in BOOT and HALT.
REQ-029 In HALT, pc SHALL hold and all inputs except resume and rst SHALL be ignored.
REQ-030 resume in HALT SHALL go to RUN with pc <= pc_plus4 when misaligned = 0; when misaligned = 1 it SHALL be ignored and HALT holds until reset.
REQ-031 halted SHALL equal 1 exactly when the state is HALT.

Reset
REQ-032 On a rising edge with rst = 0, the block SHALL set state = BOOT, pc = RESET_PC, misaligned = 0, redirect_count = 0 and halted = 0, regardless of state or other inputs.
REQ-033 Reset asserted mid-redirect or mid-HALT SHALL discard the pending action; no stale target is applied after release.
REQ-034 pc_plus4 SHALL track pc combinationally during reset (RESET_PC + 4).

Verification
REQ-035 Reset release, no stimulus -> pc = 0 with fetch_valid = 0 for one cycle, then pc = 0, 4, 8, 12 on the following cycles with fetch_valid = 1.
REQ-036 pc = 0x100, stall = 1 for 3 cycles, then jump = 1 with jump_target = 0x200 and stall = 1 -> pc holds 0x100 for 3 cycles, then pc = 0x200 and redirect_count = 1.
REQ-037 jump = 1 (target 0x300) and branch_taken = 1 (target 0x400) in the same cycle -> pc = 0x300 and redirect_count increments by 1.
REQ-038 branch_taken = 1 with branch_target = 0x202 -> pc unchanged, misaligned = 1, halted = 1 next cycle; resume = 1 afterwards -> still halted; rst = 0 -> misaligned = 0 and pc = RESET_PC.
REQ-039 halt_req = 1 and jump = 1 at pc = 0x40 -> halted = 1, pc = 0x40, redirect_count unchanged; resume = 1 -> pc = 0x44 and fetch_valid = 1.
REQ-040 Force pc = 0xFFFF_FFF8 via jump, no stall -> pc = 0xFFFF_FFFC then 0x0000_0000, misaligned stays 0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with a BOOT/RUN/HALT sequencer, redirect priority handling,
// a sticky misaligned-target flag and a count of taken redirects.
module pc_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            halted,
    output logic            misaligned,
    output logic [31:0]     redirect_count
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic            r_misaligned;
    logic [31:0]     r_redirect_count;

    logic            w_run;
    logic            w_redirect_sel;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_target_aligned;
    logic            w_redirect_take;
    logic            w_redirect_bad;
    logic            w_resume_ok;

    assign w_pc_plus4        = r_pc + XLEN'(4);
    assign w_run             = (r_state == S_RUN);
    assign w_redirect_sel    = jump | branch_taken;
    // jump outranks branch_taken when both are raised
    assign w_redirect_target = jump ? jump_target : branch_target;
    assign w_target_aligned  = (w_redirect_target[1:0] == 2'b00);
    assign w_redirect_take   = w_run && !halt_req && w_redirect_sel && w_target_aligned;
    assign w_redirect_bad    = w_run && !halt_req && w_redirect_sel && !w_target_aligned;
    assign w_resume_ok       = (r_state == S_HALT) && resume && !r_misaligned;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_RUN;
            S_RUN:   if (halt_req || w_redirect_bad) w_state_next = S_HALT;
            S_HALT:  if (w_resume_ok) w_state_next = S_RUN;
            default: w_state_next = S_BOOT;
        endcase
    end

    // output logic
    always_comb begin
        fetch_valid = w_run && (!stall || w_redirect_take);
        halted      = (r_state == S_HALT);
    end

    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect_take) begin
            w_pc_next = w_redirect_target;
        end else if (w_run && !halt_req && !w_redirect_sel && !stall) begin
            w_pc_next = w_pc_plus4;
        end else if (w_resume_ok) begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc             <= RESET_PC;
            r_misaligned     <= 1'b0;
            r_redirect_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_redirect_bad) begin
                r_misaligned <= 1'b1;
            end
            if (w_redirect_take) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign misaligned     = r_misaligned;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver predicts each cycle's outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] redirect_count;

    pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .fetch_valid    (fetch_valid),
        .halted         (halted),
        .misaligned     (misaligned),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fv;
        logic        hl;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: what the core is doing, not how the RTL encodes it
    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc",             pc,                    e.pc);
            chk("pc_plus4",       pc_plus4,              e.pc4);
            chk("fetch_valid",    {31'd0, fetch_valid},  {31'd0, e.fv});
            chk("halted",         {31'd0, halted},       {31'd0, e.hl});
            chk("misaligned",     {31'd0, misaligned},   {31'd0, e.mis});
            chk("redirect_count", redirect_count,        e.cnt);
        end
    end

    // Apply one cycle of inputs, queue the predicted outputs, advance the model
    task automatic drive(input logic r, input logic st, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic h, input logic res);
        exp_t        e;
        logic        want_redirect;
        logic [31:0] tgt;
        logic        taken;
        rst = r; stall = st; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; halt_req = h; resume = res;

        want_redirect = (m_mode == MODE_RUN) && !h && (j || b);
        tgt   = j ? jt : bt;
        taken = want_redirect && (tgt % 4 == 0);
        e.pc  = m_pc;
        e.pc4 = m_pc + 32'd4;
        e.fv  = (m_mode == MODE_RUN) && (!st || taken);
        e.hl  = (m_mode == MODE_HALT);
        e.mis = m_mis;
        e.cnt = m_cnt;
        exp_q.push_back(e);

        if (!r) begin
            m_mode = MODE_BOOT; m_pc = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (m_mode == MODE_BOOT) begin
            m_mode = MODE_RUN;
        end else if (m_mode == MODE_RUN) begin
            if (h) begin
                m_mode = MODE_HALT;
            end else if (want_redirect) begin
                if (taken) begin
                    m_pc  = tgt;
                    m_cnt = m_cnt + 32'd1;
                end else begin
                    m_mis  = 1'b1;
                    m_mode = MODE_HALT;
                end
            end else if (!st) begin
                m_pc = m_pc + 32'd4;
            end
        end else if (res && !m_mis) begin
            m_mode = MODE_RUN;
            m_pc   = m_pc + 32'd4;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt_req = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_mode = MODE_BOOT; m_pc = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;

        // reset release, free-running fetch
        idle(5);
        // stall hold then jump under stall
        drive(1, 0, 0, 0, 1, 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 32'h200, 0, 0);
        idle(1);
        // jump beats branch
        drive(1, 0, 1, 32'h400, 1, 32'h300, 0, 0);
        idle(1);
        // misaligned branch, resume ignored, reset clears
        drive(1, 0, 1, 32'h202, 0, 0, 0, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // halt overrides jump, then resume
        drive(1, 0, 0, 0, 1, 32'h40, 0, 0);
        drive(1, 0, 0, 0, 1, 32'h80, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // increment wrap
        drive(1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
        idle(3);
        // reset mid-redirect discards the target
        drive(0, 0, 0, 0, 1, 32'h500, 0, 0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, st, b, j, h, res;
            logic [31:0] bt, jt;
            r   = (m_mis || m_mode == MODE_HALT) ? ($urandom_range(0, 9) != 0)
                                                 : ($urandom_range(0, 149) != 0);
            st  = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 5) == 0);
            j   = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 39) == 0);
            res = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
            jt  = $urandom;
            if ($urandom_range(0, 9) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 9) != 0) jt[1:0] = 2'b00;
            drive(r, st, b, bt, j, jt, h, res);
        end

        idle(1);
        @(posedge clk);
        #1;
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
